// File: rtl/uart_pixel_packer.sv
// uart_pixel_packer
//   Sits between the UART byte receiver and the SDRAM write FIFO. Hunts for a
//   frame header of SYNC_LEN consecutive SYNC_BYTE values, then packs
//   BYTES_PER_PIX bytes (first byte in the MSBs) into each pixel. It emits
//   pixels on a valid/ready interface, tagged with SOF/EOL/EOF and with x/y
//   coordinates, for an H_ACTIVE x V_ACTIVE frame.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   byte_valid/byte_data  one-cycle byte strobe from the UART receiver
//   pix_valid/pix_ready   output handshake; data and flags are held while stalled
//   pix_data              packed pixel, PIX_W bits
//   pix_sof/eol/eof       first pixel of frame / last pixel of line / last of frame
//   pix_x, pix_y          coordinates of the pixel currently presented
//   busy                  receiving a frame
//   frame_done            pulse: last pixel of a frame was packed
//   timeout_err           pulse: frame aborted after an inter-byte silence
//   ovf_err               sticky: a pixel was dropped because the output was held
//   frame_cnt             completed frames (wrapping)
module uart_pixel_packer #(
  parameter int          BYTES_PER_PIX = 2,
  parameter int          H_ACTIVE      = 640,
  parameter int          V_ACTIVE      = 480,
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter int          SYNC_LEN      = 2,
  parameter int          TIMEOUT_CYC   = 500000,
  localparam int         PIX_W         = 8 * BYTES_PER_PIX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic [PIX_W-1:0] pix_data,
  output logic             pix_sof,
  output logic             pix_eol,
  output logic             pix_eof,
  output logic [11:0]      pix_x,
  output logic [11:0]      pix_y,
  output logic             busy,
  output logic             frame_done,
  output logic             timeout_err,
  output logic             ovf_err,
  output logic [15:0]      frame_cnt
);

  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic {IDLE = 1'b0, RECV = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic [2:0]       sync_cnt_reg;
  logic [1:0]       byte_idx_reg;
  logic [11:0]      x_reg, y_reg;
  logic [TMR_W-1:0] timer_reg;
  logic [PIX_W-1:0] shreg_reg;
  logic [PIX_W-1:0] shreg_next;

  logic             pix_valid_reg;
  logic [PIX_W-1:0] pix_data_reg;
  logic             pix_sof_reg, pix_eol_reg, pix_eof_reg;
  logic [11:0]      pix_x_reg, pix_y_reg;
  logic             frame_done_reg, timeout_err_reg, ovf_err_reg;
  logic [15:0]      frame_cnt_reg;

  // Shift the new byte into the LSBs; a 1-byte pixel is just the byte.
  if (BYTES_PER_PIX == 1) begin : g_bpp1
    assign shreg_next = byte_data;
  end else begin : g_bppn
    assign shreg_next = {shreg_reg[PIX_W-9:0], byte_data};
  end

  logic sync_done, rx_byte, pix_done, at_eol, at_last_line, frame_end;
  logic timed_out, out_free;

  assign sync_done    = (state_reg == IDLE) && byte_valid && (byte_data == SYNC_BYTE)
                        && (sync_cnt_reg == 3'(SYNC_LEN - 1));
  assign rx_byte      = (state_reg == RECV) && byte_valid;
  assign pix_done     = rx_byte && (byte_idx_reg == 2'(BYTES_PER_PIX - 1));
  assign at_eol       = (x_reg == 12'(H_ACTIVE - 1));
  assign at_last_line = (y_reg == 12'(V_ACTIVE - 1));
  assign frame_end    = pix_done && at_eol && at_last_line;
  // A byte arriving in the would-be timeout cycle keeps the frame alive.
  assign timed_out    = (state_reg == RECV) && !byte_valid
                        && (timer_reg == TMR_W'(TIMEOUT_CYC - 1));
  assign out_free     = !pix_valid_reg || pix_ready;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (sync_done) state_next = RECV;
      RECV:    if (frame_end || timed_out) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_cnt_reg    <= '0;
      byte_idx_reg    <= '0;
      x_reg           <= '0;
      y_reg           <= '0;
      timer_reg       <= '0;
      shreg_reg       <= '0;
      pix_valid_reg   <= 1'b0;
      pix_data_reg    <= '0;
      pix_sof_reg     <= 1'b0;
      pix_eol_reg     <= 1'b0;
      pix_eof_reg     <= 1'b0;
      pix_x_reg       <= '0;
      pix_y_reg       <= '0;
      frame_done_reg  <= 1'b0;
      timeout_err_reg <= 1'b0;
      ovf_err_reg     <= 1'b0;
      frame_cnt_reg   <= '0;
    end else begin
      frame_done_reg  <= 1'b0;
      timeout_err_reg <= 1'b0;

      if (state_reg == IDLE) begin
        if (byte_valid) begin
          if (sync_done) begin
            sync_cnt_reg <= '0;
            byte_idx_reg <= '0;
            x_reg        <= '0;
            y_reg        <= '0;
            timer_reg    <= '0;
            ovf_err_reg  <= 1'b0;
          end else if (byte_data == SYNC_BYTE) begin
            sync_cnt_reg <= sync_cnt_reg + 3'd1;
          end else begin
            sync_cnt_reg <= '0;
          end
        end
      end else begin
        if (byte_valid) begin
          shreg_reg <= shreg_next;
          timer_reg <= '0;
          if (pix_done) begin
            byte_idx_reg <= '0;
            // Geometry advances even for a dropped pixel so later pixels
            // keep their true position in the frame.
            if (frame_end) begin
              x_reg          <= '0;
              y_reg          <= '0;
              frame_done_reg <= 1'b1;
              frame_cnt_reg  <= frame_cnt_reg + 16'd1;
            end else if (at_eol) begin
              x_reg <= '0;
              y_reg <= y_reg + 12'd1;
            end else begin
              x_reg <= x_reg + 12'd1;
            end
          end else begin
            byte_idx_reg <= byte_idx_reg + 2'd1;
          end
        end else if (timed_out) begin
          // Abort: partial pixel is discarded; the output register drains as usual.
          timeout_err_reg <= 1'b1;
          timer_reg       <= '0;
          byte_idx_reg    <= '0;
        end else begin
          timer_reg <= timer_reg + TMR_W'(1);
        end
      end

      // Single-entry output register: load when empty or being consumed,
      // otherwise drop the new pixel and flag the overflow.
      if (pix_done && out_free) begin
        pix_valid_reg <= 1'b1;
        pix_data_reg  <= shreg_next;
        pix_x_reg     <= x_reg;
        pix_y_reg     <= y_reg;
        pix_sof_reg   <= (x_reg == 12'd0) && (y_reg == 12'd0);
        pix_eol_reg   <= at_eol;
        pix_eof_reg   <= at_eol && at_last_line;
      end else begin
        if (pix_ready) pix_valid_reg <= 1'b0;
        if (pix_done) ovf_err_reg <= 1'b1;
      end
    end
  end

  assign pix_valid   = pix_valid_reg;
  assign pix_data    = pix_data_reg;
  assign pix_sof     = pix_sof_reg;
  assign pix_eol     = pix_eol_reg;
  assign pix_eof     = pix_eof_reg;
  assign pix_x       = pix_x_reg;
  assign pix_y       = pix_y_reg;
  assign busy        = (state_reg == RECV);
  assign frame_done  = frame_done_reg;
  assign timeout_err = timeout_err_reg;
  assign ovf_err     = ovf_err_reg;
  assign frame_cnt   = frame_cnt_reg;

endmodule

// File: tb/tb_uart_pixel_packer.sv
// Testbench for uart_pixel_packer: small frame geometry and short timeout so
// whole frames fit in a short run. Every accepted pixel is checked against a
// queue of expected pixels whose coordinates and flags come from the pixel's
// index in the frame.
module tb_uart_pixel_packer;

  localparam int         BPP  = 2;
  localparam int         PW   = 8 * BPP;
  localparam int         H    = 8;
  localparam int         V    = 4;
  localparam int         SLEN = 2;
  localparam int         TO   = 64;
  localparam logic [7:0] SB   = 8'hA5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'h00;
  logic          pix_ready = 1'b1;
  logic          pix_valid;
  logic [PW-1:0] pix_data;
  logic          pix_sof, pix_eol, pix_eof;
  logic [11:0]   pix_x, pix_y;
  logic          busy, frame_done, timeout_err, ovf_err;
  logic [15:0]   frame_cnt;

  always #5 clk = ~clk;

  uart_pixel_packer #(
    .BYTES_PER_PIX(BPP), .H_ACTIVE(H), .V_ACTIVE(V),
    .SYNC_BYTE(SB), .SYNC_LEN(SLEN), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_eof(pix_eof),
    .pix_x(pix_x), .pix_y(pix_y), .busy(busy), .frame_done(frame_done),
    .timeout_err(timeout_err), .ovf_err(ovf_err), .frame_cnt(frame_cnt)
  );

  typedef struct packed {
    logic [PW-1:0] d;
    logic [11:0]   x;
    logic [11:0]   y;
    logic          sof;
    logic          eol;
    logic          eof;
  } px_t;

  px_t exp_q[$];
  int  total = 0;
  int  bad = 0;
  int  fd_cnt = 0;
  int  to_cnt = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference pixel: position and flags follow from the index in the frame.
  function automatic px_t exp_px(input logic [PW-1:0] v, input int idx);
    px_t p;
    int  px, py;
    px    = idx % H;
    py    = idx / H;
    p.d   = v;
    p.x   = 12'(px);
    p.y   = 12'(py);
    p.sof = (idx == 0);
    p.eol = (px == H - 1);
    p.eof = (idx == H * V - 1);
    return p;
  endfunction

  // Scoreboard: each accepted pixel must match the oldest expected one.
  always @(negedge clk) begin : mon
    px_t got;
    if (!rst) begin
      if (frame_done) fd_cnt++;
      if (timeout_err) to_cnt++;
      if (pix_valid && pix_ready) begin
        got = {pix_data, pix_x, pix_y, pix_sof, pix_eol, pix_eof};
        if (exp_q.size() == 0) check("pixel_expected", 64'(exp_q.size()), 64'd1);
        else check("pixel", 64'(got), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
  endtask

  task automatic send_sync();
    repeat (SLEN) send_byte(SB, 0);
  endtask

  task automatic send_pixel(input logic [PW-1:0] v, input int idx, input bit keep,
                            input int maxgap);
    if (keep) exp_q.push_back(exp_px(v, idx));
    for (int b = 0; b < BPP; b++)
      send_byte(v[PW-1-8*b -: 8], int'($urandom_range(0, maxgap)));
  endtask

  function automatic logic [PW-1:0] rand_pix();
    logic [PW-1:0] v;
    v = PW'($urandom);
    if ($urandom_range(0, 7) == 0) v[PW-1 -: 8] = SB;  // header value as pixel data
    return v;
  endfunction

  task automatic send_rest(input int start, input int maxgap);
    for (int idx = start; idx < H * V; idx++) send_pixel(rand_pix(), idx, 1'b1, maxgap);
  endtask

  // Called right after the last byte of a frame.
  task automatic end_frame(input string tag, input int fc);
    check({tag, "_frame_done"}, 64'(frame_done), 64'd1);
    check({tag, "_busy_low"}, 64'(busy), 64'd0);
    tick();
    check({tag, "_frame_done_pulse"}, 64'(frame_done), 64'd0);
    tick();
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(fc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int to_before;
    logic [7:0] g;

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    check("rst_valid", 64'(pix_valid), 64'd0);
    check("rst_data", 64'(pix_data), 64'd0);
    check("rst_xy", 64'({pix_x, pix_y}), 64'd0);
    check("rst_flags", 64'({pix_sof, pix_eol, pix_eof}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pulses", 64'({frame_done, timeout_err, ovf_err}), 64'd0);
    check("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    rst = 1'b0;
    tick();

    // T1/T2: first pixel latency and a complete frame
    send_sync();
    check("t1_busy", 64'(busy), 64'd1);
    exp_q.push_back(exp_px(16'h1234, 0));
    send_byte(8'h12, 0);
    check("t1_not_early", 64'(pix_valid), 64'd0);
    send_byte(8'h34, 0);
    check("t1_valid", 64'(pix_valid), 64'd1);
    check("t1_data", 64'(pix_data), 64'h1234);
    check("t1_sof", 64'(pix_sof), 64'd1);
    send_rest(1, 3);
    end_frame("t2", 1);

    // T3: broken header restarts the hunt
    send_byte(SB, 0);
    send_byte(8'h3C, 0);
    check("t3_hunting", 64'(busy), 64'd0);
    send_sync();
    check("t3_busy", 64'(busy), 64'd1);
    send_pixel(16'h1122, 0, 1'b1, 0);
    send_rest(1, 2);
    end_frame("t3", 2);

    // Randomized frames with junk before the header
    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j < int'($urandom_range(0, 4)); j++) begin
        g = 8'($urandom);
        if (g == SB) g = 8'h5A;
        send_byte(g, int'($urandom_range(0, 2)));
      end
      if ($urandom_range(0, 1) == 1) begin
        send_byte(SB, 0);
        send_byte(8'h00, 1);
      end
      send_sync();
      send_rest(0, 4);
      end_frame("rnd", 3 + f);
    end

    // T4: output held -> second pixel dropped, geometry keeps advancing
    send_sync();
    pix_ready = 1'b0;
    send_pixel(16'hAABB, 0, 1'b1, 0);
    check("t4_valid", 64'(pix_valid), 64'd1);
    send_pixel(16'hCCDD, 1, 1'b0, 0);
    check("t4_ovf", 64'(ovf_err), 64'd1);
    check("t4_held_data", 64'(pix_data), 64'hAABB);
    check("t4_held_x", 64'(pix_x), 64'd0);
    repeat (3) tick();
    check("t4_still_valid", 64'(pix_valid), 64'd1);
    check("t4_still_data", 64'(pix_data), 64'hAABB);
    pix_ready = 1'b1;
    tick();
    check("t4_drained", 64'(pix_valid), 64'd0);
    send_pixel(16'hEEFF, 2, 1'b1, 0);
    check("t4_next_x", 64'(pix_x), 64'd2);
    send_rest(3, 1);
    end_frame("t4", 6);
    check("t4_ovf_sticky", 64'(ovf_err), 64'd1);

    // T5: inter-byte timeout, then a byte landing in the timeout cycle
    send_sync();
    check("t5_ovf_cleared", 64'(ovf_err), 64'd0);
    to_before = to_cnt;
    send_byte(8'h77, 0);
    k = 0;
    while (!timeout_err && k < TO * 4) begin
      tick();
      k++;
    end
    check("t5_timeout_latency", 64'(k), 64'(TO));
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_no_pixel", 64'(pix_valid), 64'd0);
    tick();
    check("t5_pulse", 64'(timeout_err), 64'd0);
    check("t5_to_count", 64'(to_cnt), 64'(to_before + 1));
    send_sync();
    send_pixel(rand_pix(), 0, 1'b1, 0);
    repeat (TO - 1) tick();
    send_pixel(rand_pix(), 1, 1'b1, 0);
    check("t5_byte_wins", 64'(busy), 64'd1);
    send_rest(2, 3);
    end_frame("t5", 7);
    check("t5_no_extra_to", 64'(to_cnt), 64'(to_before + 1));

    // T6: reset mid-frame
    send_sync();
    for (int idx = 0; idx < 13; idx++) send_pixel(rand_pix(), idx, 1'b1, 1);
    check("t6_mid_x", 64'(pix_x), 64'd4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("t6_valid", 64'(pix_valid), 64'd0);
    check("t6_xy", 64'({pix_x, pix_y}), 64'd0);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_frame_cnt", 64'(frame_cnt), 64'd0);
    tick();
    send_sync();
    send_rest(0, 2);
    end_frame("t6", 1);

    check("frame_done_total", 64'(fd_cnt), 64'd8);
    check("timeout_total", 64'(to_cnt), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
